// File: rtl/npc_pkg.sv
// Shared definitions for the next-PC unit: control-flow op encodings and PC geometry.
package npc_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRZ  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

endpackage

// File: rtl/npc_unit_rstack.sv
// Hardware return-address LIFO: synchronous push, asynchronous read of the top entry.
// Config macro NPC_RSTACK_CHECK_EN: when defined, pushes at full and pops at empty are
// suppressed and raise sticky flags; otherwise the pointer wraps circularly.
module rstack
    import npc_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned Aw    = $clog2(Depth),
    parameter int unsigned Dw    = PC_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [Dw-1:0] wdata_i,
    output logic [Dw-1:0] top_o,
    output logic [Aw:0]   depth_o,
    output logic          ovf_o,
    output logic          unf_o
);

    localparam logic [Aw:0]   DepthMax = (Aw + 1)'(Depth);
    localparam logic [Aw:0]   CntOne   = 1;
    localparam logic [Aw-1:0] PtrOne   = 1;

    logic [Dw-1:0] mem_q [Depth];
    logic [Aw-1:0] ptr_q, ptr_d, top_idx;
    logic [Aw:0]   depth_q, depth_d;
    logic          empty, full, do_push, do_pop;

    assign empty = (depth_q == '0);
    assign full  = (depth_q == DepthMax);

`ifdef NPC_RSTACK_CHECK_EN
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;
`else
    // Pointer keeps moving past the bounds so overflow overwrites the oldest entry.
    assign do_push = push_i;
    assign do_pop  = pop_i;
`endif

    // Next pointer and occupancy; occupancy saturates even when the pointer wraps.
    always_comb begin
        ptr_d   = ptr_q;
        depth_d = depth_q;
        if (do_push) begin
            ptr_d = ptr_q + PtrOne;
            if (!full) depth_d = depth_q + CntOne;
        end else if (do_pop) begin
            ptr_d = ptr_q - PtrOne;
            if (!empty) depth_d = depth_q - CntOne;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            depth_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
        end
    end

    // Stack storage, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[ptr_q] <= wdata_i;
    end

    assign top_idx = ptr_q - PtrOne;
    assign top_o   = mem_q[top_idx];
    assign depth_o = depth_q;

`ifdef NPC_RSTACK_CHECK_EN
    logic ovf_q, unf_q;

    // Sticky bound-violation flags, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (push_i & full);
            unf_q <= unf_q | (pop_i & empty);
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`else
    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
`endif

endmodule

// File: rtl/npc_unit.sv
// Next-PC generator for the Forth core: op decode, nPC mux and the return-address stack.
// Config macro NPC_RSTACK_CHECK_EN: enables return-stack bounds checking.
module npc_unit
    import npc_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 16,
    parameter int unsigned RS_AW    = $clog2(RS_DEPTH)
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [PC_W-1:0] PC,
    input  logic [2:0]      Op,
    input  logic [PC_W-1:0] Target,
    input  logic [PC_W-1:0] Cond,
    input  logic            Stall,
    output logic [PC_W-1:0] nPC,
    output logic [RS_AW:0]  RsDepth,
    output logic            RsOvf,
    output logic            RsUnf
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] rs_top;
    logic            rs_push, rs_pop;
    logic            ret_target_ok;

    assign pc_inc  = PC + PC_STEP;
    assign rs_push = ~Stall & (Op == OP_CALL);
    assign rs_pop  = ~Stall & (Op == OP_RET);

`ifdef NPC_RSTACK_CHECK_EN
    // A checked RET from an empty stack falls through instead of using stale data.
    assign ret_target_ok = (RsDepth != '0);
`else
    assign ret_target_ok = 1'b1;
`endif

    rstack #(
        .Depth (RS_DEPTH),
        .Aw    (RS_AW),
        .Dw    (PC_W)
    ) u_rstack (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .push_i  (rs_push),
        .pop_i   (rs_pop),
        .wdata_i (pc_inc),
        .top_o   (rs_top),
        .depth_o (RsDepth),
        .ovf_o   (RsOvf),
        .unf_o   (RsUnf)
    );

    // Combinational next-PC select; stall has priority over every op.
    always_comb begin
        nPC = pc_inc;
        if (Stall) begin
            nPC = PC;
        end else begin
            case (Op)
                OP_SEQ:  nPC = pc_inc;
                OP_JMP:  nPC = Target;
                OP_BRZ:  nPC = (Cond == '0) ? Target : pc_inc;
                OP_CALL: nPC = Target;
                OP_RET:  nPC = ret_target_ok ? rs_top : pc_inc;
                default: nPC = pc_inc;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit against a queue-based return-stack model.
module tb_npc_unit;

    localparam int unsigned DEPTH = 16;
    localparam logic [2:0] SEQ  = 3'd0;
    localparam logic [2:0] JMP  = 3'd1;
    localparam logic [2:0] BRZ  = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;

`ifdef NPC_RSTACK_CHECK_EN
    localparam bit CHECKED = 1'b1;
`else
    localparam bit CHECKED = 1'b0;
`endif

    logic        Clk;
    logic        Rst_n;
    logic [31:0] PC;
    logic [2:0]  Op;
    logic [31:0] Target;
    logic [31:0] Cond;
    logic        Stall;
    logic [31:0] nPC;
    logic [4:0]  RsDepth;
    logic        RsOvf;
    logic        RsUnf;

    int errors = 0;
    int checks = 0;

    // Reference model: the return stack as a queue of addresses, newest at the back.
    logic [31:0] mq[$];
    bit          m_ovf;
    bit          m_unf;

    npc_unit #(
        .RS_DEPTH (16),
        .RS_AW    (4)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .PC      (PC),
        .Op      (Op),
        .Target  (Target),
        .Cond    (Cond),
        .Stall   (Stall),
        .nPC     (nPC),
        .RsDepth (RsDepth),
        .RsOvf   (RsOvf),
        .RsUnf   (RsUnf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic logic [31:0] model_npc(input logic [2:0] op, input logic [31:0] pc,
                                              input logic [31:0] tgt, input logic [31:0] cond,
                                              input logic stall);
        if (stall) return pc;
        case (op)
            JMP:  return tgt;
            BRZ:  return (cond == 0) ? tgt : pc + 32'd4;
            CALL: return tgt;
            RET:  return (mq.size() == 0) ? pc + 32'd4 : mq[mq.size() - 1];
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic model_step(input logic [2:0] op, input logic [31:0] pc, input logic stall);
        if (stall) return;
        if (op == CALL) begin
            if (CHECKED && mq.size() == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                mq.push_back(pc + 32'd4);
                if (mq.size() > DEPTH) void'(mq.pop_front());
            end
        end else if (op == RET) begin
            if (mq.size() == 0) begin
                if (CHECKED) m_unf = 1'b1;
            end else begin
                void'(mq.pop_back());
            end
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] cond, input logic stall);
        Op     = op;
        PC     = pc;
        Target = tgt;
        Cond   = cond;
        Stall  = stall;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        drive(SEQ, 32'h0, 32'h0, 32'h0, 1'b0);
        model_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        drive(SEQ, 32'h0, 32'h0, 32'h0, 1'b0);
        model_reset();
        #1;
        checks++;
        if (nPC !== 32'h4) begin
            errors++; $display("FAIL reset_npc got=%h exp=%h", nPC, 32'h4);
        end
        checks++;
        if (RsDepth !== 5'd0) begin
            errors++; $display("FAIL reset_depth got=%0d exp=0", RsDepth);
        end
        checks++;
        if (RsOvf !== 1'b0 || RsUnf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got=%b%b exp=00", RsOvf, RsUnf);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_seq_brz();
        logic [31:0] pcs [4];
        logic [2:0]  ops [4];
        logic [31:0] conds [4];
        logic [31:0] exps [4];
        pcs   = '{32'h100, 32'h180, 32'h180, 32'hFFFF_FFFC};
        ops   = '{SEQ, BRZ, BRZ, SEQ};
        conds = '{32'h0, 32'h0, 32'h1, 32'h0};
        exps  = '{32'h104, 32'h200, 32'h184, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            drive(ops[i], pcs[i], 32'h200, conds[i], 1'b0);
            #1;
            checks++;
            if (nPC !== exps[i]) begin
                errors++; $display("FAIL seq_brz[%0d] got=%h exp=%h", i, nPC, exps[i]);
            end
            @(posedge Clk);
            model_step(ops[i], pcs[i], 1'b0);
        end
        #1;
        checks++;
        if (RsDepth !== 5'd0 || RsOvf !== 1'b0 || RsUnf !== 1'b0) begin
            errors++; $display("FAIL seq_brz_state got=%0d/%b%b exp=0/00", RsDepth, RsOvf, RsUnf);
        end
    endtask

    task automatic test_call_ret();
        @(negedge Clk);
        drive(CALL, 32'h40, 32'h300, 32'h0, 1'b0);
        #1;
        checks++;
        if (nPC !== 32'h300) begin
            errors++; $display("FAIL call_npc got=%h exp=%h", nPC, 32'h300);
        end
        @(posedge Clk);
        model_step(CALL, 32'h40, 1'b0);
        #1;
        checks++;
        if (RsDepth !== 5'd1) begin
            errors++; $display("FAIL call_depth got=%0d exp=1", RsDepth);
        end
        @(negedge Clk);
        drive(RET, 32'h308, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (nPC !== 32'h44) begin
            errors++; $display("FAIL ret_npc got=%h exp=%h", nPC, 32'h44);
        end
        @(posedge Clk);
        model_step(RET, 32'h308, 1'b0);
        #1;
        checks++;
        if (RsDepth !== 5'd0) begin
            errors++; $display("FAIL ret_depth got=%0d exp=0", RsDepth);
        end
    endtask

    task automatic test_stall();
        @(negedge Clk);
        drive(CALL, 32'h500, 32'h900, 32'h0, 1'b1);
        #1;
        checks++;
        if (nPC !== 32'h500) begin
            errors++; $display("FAIL stall_npc got=%h exp=%h", nPC, 32'h500);
        end
        @(posedge Clk);
        model_step(CALL, 32'h500, 1'b1);
        #1;
        checks++;
        if (RsDepth !== 5'd0) begin
            errors++; $display("FAIL stall_depth got=%0d exp=0", RsDepth);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_first;
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            @(negedge Clk);
            drive(CALL, 32'h1000 + 32'(i) * 32'h10, 32'h8000, 32'h0, 1'b0);
            @(posedge Clk);
            model_step(CALL, 32'h1000 + 32'(i) * 32'h10, 1'b0);
        end
        #1;
        checks++;
        if (RsDepth !== 5'd16) begin
            errors++; $display("FAIL ovf_depth got=%0d exp=16", RsDepth);
        end
        checks++;
        if (RsOvf !== CHECKED) begin
            errors++; $display("FAIL ovf_flag got=%b exp=%b", RsOvf, CHECKED);
        end
        exp_first = CHECKED ? 32'h1000 + 32'd15 * 32'h10 + 32'd4
                            : 32'h1000 + 32'd16 * 32'h10 + 32'd4;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            drive(RET, 32'h9000, 32'h0, 32'h0, 1'b0);
            #1;
            exp = model_npc(RET, 32'h9000, 32'h0, 32'h0, 1'b0);
            if (i == 0) begin
                checks++;
                if (nPC !== exp_first) begin
                    errors++; $display("FAIL ovf_first_ret got=%h exp=%h", nPC, exp_first);
                end
            end
            checks++;
            if (nPC !== exp) begin
                errors++; $display("FAIL ovf_ret[%0d] got=%h exp=%h", i, nPC, exp);
            end
            @(posedge Clk);
            model_step(RET, 32'h9000, 1'b0);
        end
        #1;
        checks++;
        if (RsDepth !== 5'd0) begin
            errors++; $display("FAIL ovf_drain_depth got=%0d exp=0", RsDepth);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        @(negedge Clk);
        drive(RET, 32'h700, 32'h0, 32'h0, 1'b0);
        #1;
        if (CHECKED) begin
            checks++;
            if (nPC !== 32'h704) begin
                errors++; $display("FAIL unf_npc got=%h exp=%h", nPC, 32'h704);
            end
        end
        @(posedge Clk);
        model_step(RET, 32'h700, 1'b0);
        #1;
        checks++;
        if (RsUnf !== m_unf || RsDepth !== 5'd0) begin
            errors++; $display("FAIL unf_flag got=%b/%0d exp=%b/0", RsUnf, RsDepth, m_unf);
        end
        // Async reset during the cycle must clear state before the next edge.
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (RsUnf !== 1'b0 || RsDepth !== 5'd0) begin
            errors++; $display("FAIL unf_async_rst got=%b/%0d exp=0/0", RsUnf, RsDepth);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_async_reset_depth();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            drive(CALL, 32'h2000 + 32'(i) * 32'h8, 32'h3000, 32'h0, 1'b0);
            @(posedge Clk);
            model_step(CALL, 32'h2000 + 32'(i) * 32'h8, 1'b0);
        end
        #1;
        checks++;
        if (RsDepth !== 5'd3) begin
            errors++; $display("FAIL pre_rst_depth got=%0d exp=3", RsDepth);
        end
        @(negedge Clk);
        drive(SEQ, 32'h0, 32'h0, 32'h0, 1'b0);
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (RsDepth !== 5'd0) begin
            errors++; $display("FAIL async_rst_depth got=%0d exp=0", RsDepth);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] pc, tgt, cond, exp;
        logic        stall;
        int          r;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      op = SEQ;
            else if (r < 30) op = JMP;
            else if (r < 45) op = BRZ;
            else if (r < 67) op = CALL;
            else if (r < 92) op = RET;
            else             op = 3'($urandom_range(5, 7));
            // Unchecked underflow reads undefined stale data; keep it out of random traffic.
            if (!CHECKED && op == RET && mq.size() == 0) op = SEQ;
            stall = ($urandom_range(0, 9) == 0);
            pc    = $urandom;
            tgt   = $urandom;
            cond  = ($urandom_range(0, 1) == 1) ? 32'h0 : $urandom;
            @(negedge Clk);
            drive(op, pc, tgt, cond, stall);
            #1;
            exp = model_npc(op, pc, tgt, cond, stall);
            checks++;
            if (nPC !== exp) begin
                errors++;
                $display("FAIL rand_npc[%0d] op=%0d stall=%b got=%h exp=%h", n, op, stall, nPC, exp);
            end
            @(posedge Clk);
            model_step(op, pc, stall);
            #1;
            checks++;
            if (RsDepth !== 5'(mq.size()) || RsOvf !== m_ovf || RsUnf !== m_unf) begin
                errors++;
                $display("FAIL rand_state[%0d] got=%0d/%b%b exp=%0d/%b%b", n, RsDepth, RsOvf,
                         RsUnf, mq.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(SEQ, 32'h0, 32'h0, 32'h0, 1'b0);
        model_reset();
        test_reset();
        test_seq_brz();
        test_call_ret();
        test_stall();
        test_overflow();
        test_underflow();
        test_async_reset_depth();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
